deserializer_with_handshake: RTL and testbench
==============================================

Name: deserializer_with_handshake

Overview:
- Serial-to-parallel converter: collects WIDTH single-bit samples from a valid-qualified serial stream and presents each completed word on a valid/ready parallel port.
- It is the receiving end for the mux-based serializers in the combinational/sequential exercise set. It reassembles the word that a sel-driven mux chain shifted out one bit per cycle.
- A holding register lets assembly of the next word overlap with downstream backpressure.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1: first accepted bit lands in parallel_data[WIDTH-1]; 0: first accepted bit lands in parallel_data[0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- serial_valid  input  1  serial_data is valid this cycle.
- serial_data  input  1  serial bit.
- serial_ready  output  1  block accepts a bit this cycle; a transfer occurs when serial_valid & serial_ready.
- parallel_valid  output  1  parallel_data holds a completed word.
- parallel_data  output  WIDTH  completed word.
- parallel_ready  input  1  downstream accepts; a transfer occurs when parallel_valid & parallel_ready.
- bit_count  output  $clog2(WIDTH)  number of bits of the word currently being assembled, 0..WIDTH-1.

Behaviour:
- Reset (rst_n low, asynchronous): shift register = 0, bit_count = 0, parallel_valid = 0, parallel_data = 0.
  - serial_ready is combinational; it reads 1 while in reset-released idle.
  - Reset mid-word discards the partial word.
  - Reset with parallel_valid = 1 drops the held word; no transfer is reported.
- Assembly:
  - On each serial transfer, the bit is written into the shift register at position bit_count.
  - If MSB_FIRST = 1, it is written at index WIDTH-1-bit_count instead.
  - bit_count then increments.
  - Cycles with serial_valid = 0 leave all state unchanged; gaps of any length are allowed.
- Completion:
  - The serial transfer with bit_count == WIDTH-1 completes the word.
  - On that edge, the full word (including the final bit) is loaded into parallel_data and parallel_valid is set.
  - bit_count wraps to 0.
  - Latency: parallel_valid is high in the cycle after the last bit is accepted.
- Output state machine, states EMPTY and FULL:
  - EMPTY -> FULL on word completion.
  - FULL -> EMPTY on a parallel transfer with no completion in the same cycle.
  - FULL -> FULL on a simultaneous parallel transfer and completion: the new word replaces the old one with no bubble, and parallel_valid stays 1.
- Output stability: while parallel_valid = 1 and parallel_ready = 0, parallel_data must not change.
- Backpressure:
  - serial_ready = !(parallel_valid && !parallel_ready && bit_count == WIDTH-1).
  - Bits 0..WIDTH-2 of the next word are always accepted.
  - Only the completing bit stalls, and only while the held word is unconsumed.
  - A stalled bit is accepted on the first cycle parallel_ready = 1.
- serial_ready depends combinationally on parallel_ready; no other combinational path from input to output exists.
- parallel_data is only meaningful while parallel_valid = 1. It holds its last value after the word is consumed.

Test Plan:
- WIDTH=8, MSB_FIRST=1, parallel_ready=1, serial bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> parallel_valid=1 for exactly one cycle, the cycle after the 8th bit, with parallel_data=8'hA5; bit_count reads 0..7 then 0.
- Same bit sequence with MSB_FIRST=0 -> parallel_data=8'hA5; sequence 1,1,0,0,0,0,0,0 -> 8'h03.
- serial_valid toggled 1,0,0,1,... across 8 bits of 8'h3C -> word 8'h3C; parallel_valid rises only after the 8th valid bit; state is unchanged during gaps.
- parallel_ready=0 while streaming 16 bits (8'hF0 then 8'h0F):
  - parallel_data holds 8'hF0.
  - serial_ready drops with bit_count=7 of the second word.
  - Raise parallel_ready for one cycle -> 8'hF0 consumed, last bit accepted the same cycle, next cycle parallel_data=8'h0F and parallel_valid stays 1.
- Continuous stream of 3 words 8'h11, 8'h22, 8'h33 with parallel_ready=1 -> three valid pulses 8 cycles apart; serial_ready is never low.
- Assert rst_n=0 asynchronously after 5 bits, then after a held word -> parallel_valid=0 and bit_count=0 immediately. A following full 8'hC3 transfer yields exactly 8'hC3 with no leftover bits.

Source files
------------

// File: rtl/deserializer_with_handshake.sv
// deserializer_with_handshake
// Collects WIDTH valid-qualified serial bits into a word and presents each
// completed word on a valid/ready parallel port. A single holding register
// (parallel_data) lets the next word assemble while downstream is stalled;
// only the bit that would complete that next word is held off.

module deserializer_with_handshake #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     serial_valid,
  input  logic                     serial_data,
  output logic                     serial_ready,
  output logic                     parallel_valid,
  output logic [WIDTH-1:0]         parallel_data,
  input  logic                     parallel_ready,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH);

  // Index of the bit that completes a word.
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  // Output holding register states.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_bit_count;

  logic             w_last_bit;
  logic             w_serial_xfer;
  logic             w_parallel_xfer;
  logic             w_complete;
  logic [CW-1:0]    w_wr_idx;
  logic [WIDTH-1:0] w_shift_next;
  logic [0:0]       w_state_next;
  logic             w_full;

  assign w_full     = (r_state == ST_FULL);
  assign w_last_bit = (r_bit_count == LAST_IDX);

  // The completing bit waits only while the held word is still unconsumed;
  // the same-cycle parallel_ready lets replacement happen without a bubble.
  assign serial_ready = !(w_full && !parallel_ready && w_last_bit);

  assign w_serial_xfer   = serial_valid && serial_ready;
  assign w_parallel_xfer = w_full && parallel_ready;
  assign w_complete      = w_serial_xfer && w_last_bit;

  // Bit placement: first accepted bit goes to the MSB or the LSB.
  assign w_wr_idx = MSB_FIRST ? (LAST_IDX - r_bit_count) : r_bit_count;

  // Shift register contents after this cycle's serial transfer, if any.
  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned
    // (which would infer a latch).
    w_shift_next = r_shift;
    if (w_serial_xfer) begin
      w_shift_next[w_wr_idx] = serial_data;
    end
  end

  // Holding-register state transitions.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_complete) begin
          w_state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        // A completion in the same cycle as a drain keeps the register full.
        if (w_parallel_xfer && !w_complete) begin
          w_state_next = ST_EMPTY;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // Word assembly: bit position counter and partial-word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all clocked state so every
      // register samples pre-edge values regardless of block ordering.
      r_shift     <= '0;
      r_bit_count <= '0;
    end else if (w_serial_xfer) begin
      r_shift     <= w_shift_next;
      r_bit_count <= w_last_bit ? '0 : r_bit_count + 1'b1;
    end
  end

  // Output holding register: loads the full word (including the final bit)
  // on completion and otherwise holds, so data is stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, so a dropped word can never
      // reappear and the port reads a defined value straight out of reset.
      r_state <= ST_EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_complete) begin
        r_data <= w_shift_next;
      end
    end
  end

  assign parallel_valid = w_full;
  assign parallel_data  = r_data;
  assign bit_count      = r_bit_count;

  // A held, unconsumed word must not change underneath the consumer.
  a_data_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (parallel_valid && !parallel_ready) |=> $stable(parallel_data)
  );

endmodule

// File: tb/tb_deserializer_with_handshake.sv
// Bench for deserializer_with_handshake: one MSB-first and one LSB-first
// instance share the same stimulus; a queue-based model of the word stream
// is compared against both on every falling edge, and directed literal
// checks pin the model to hand-computed words.

module tb_deserializer_with_handshake;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         serial_valid = 1'b0;
  logic         serial_data = 1'b0;
  logic         parallel_ready = 1'b0;

  logic         sready_m, pvalid_m, sready_l, pvalid_l;
  logic [W-1:0] pdata_m, pdata_l;
  logic [2:0]   cnt_m, cnt_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  deserializer_with_handshake #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n),
    .serial_valid(serial_valid), .serial_data(serial_data), .serial_ready(sready_m),
    .parallel_valid(pvalid_m), .parallel_data(pdata_m), .parallel_ready(parallel_ready),
    .bit_count(cnt_m)
  );

  deserializer_with_handshake #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n),
    .serial_valid(serial_valid), .serial_data(serial_data), .serial_ready(sready_l),
    .parallel_valid(pvalid_l), .parallel_data(pdata_l), .parallel_ready(parallel_ready),
    .bit_count(cnt_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: bits accepted so far + one held word ----------
  bit           m_q[$];
  bit           m_full = 1'b0;
  logic [W-1:0] m_word_m = '0;
  logic [W-1:0] m_word_l = '0;

  initial begin
    forever begin
      logic         er;
      logic [W-1:0] wm, wl;
      @(negedge clk);
      if (!rst_n) begin
        m_q.delete();
        m_full   = 1'b0;
        m_word_m = '0;
        m_word_l = '0;
      end else begin
        er = !(m_full && !parallel_ready && (m_q.size() == W - 1));
        check("mdl_sready_m", sready_m, er);
        check("mdl_sready_l", sready_l, er);
        check("mdl_valid_m", pvalid_m, m_full);
        check("mdl_valid_l", pvalid_l, m_full);
        check("mdl_cnt_m", cnt_m, m_q.size());
        check("mdl_cnt_l", cnt_l, m_q.size());
        check("mdl_data_m", pdata_m, m_word_m);
        check("mdl_data_l", pdata_l, m_word_l);
        // Advance to the state after the coming rising edge.
        if (serial_valid && er) m_q.push_back(serial_data);
        if (m_q.size() == W) begin
          wm = '0;
          wl = '0;
          for (int i = 0; i < W; i++) begin
            wm = {wm[W-2:0], m_q[i]};          // first bit ends up as MSB
            wl = wl | (W'(m_q[i]) << i);       // first bit ends up as LSB
          end
          m_word_m = wm;
          m_word_l = wl;
          m_full   = 1'b1;
          m_q.delete();
        end else if (m_full && parallel_ready) begin
          m_full = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  int stalls_total;

  task automatic send_bit(input logic b, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    serial_valid = 1'b1;
    serial_data  = b;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (sready_m) done = 1'b1;
      else          stalls++;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    serial_valid = 1'b0;
  endtask

  // Sends w[7] first; the MSB-first instance reassembles w itself.
  task automatic send_word(input logic [W-1:0] w);
    int st;
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(w[i], st);
      stalls_total += st;
    end
  endtask

  task automatic idle(input int n);
    serial_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ------------------------------------------
  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] words_m [3];
    logic [W-1:0] words_l [3];
    int st;
    stalls_total = 0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    parallel_ready = 1'b1;
    check("rst_valid", pvalid_m, 1'b0);
    check("rst_data", pdata_m, 8'h00);
    check("rst_cnt", cnt_m, 3'd0);
    check("rst_sready", sready_m, 1'b1);

    // T1: A5 back-to-back, bit_count 0..7 then 0, one-cycle valid pulse.
    pat = 8'hA5;
    for (int i = W - 1; i >= 0; i--) begin
      check("t1_cnt", cnt_m, 32'(W - 1 - i));
      send_bit(pat[i], st);
    end
    check("t1_valid", pvalid_m, 1'b1);
    check("t1_data_m", pdata_m, 8'hA5);
    check("t1_data_l", pdata_l, 8'hA5);
    check("t1_cnt_wrap", cnt_m, 3'd0);
    idle(1);
    check("t1_valid_drop", pvalid_m, 1'b0);

    // T2: bits 1,1,0,0,0,0,0,0.
    send_word(8'hC0);
    check("t2_data_m", pdata_m, 8'hC0);
    check("t2_data_l", pdata_l, 8'h03);
    idle(1);

    // T3: 3C with two idle cycles between bits.
    pat = 8'h3C;
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(pat[i], st);
      if (i > 0) idle(2);
      if (i == 1) begin
        check("t3_no_early_valid", pvalid_m, 1'b0);
        check("t3_cnt7", cnt_m, 3'd7);
      end
    end
    check("t3_valid", pvalid_m, 1'b1);
    check("t3_data_m", pdata_m, 8'h3C);
    check("t3_data_l", pdata_l, 8'h3C);
    idle(1);

    // T4: backpressure across F0 then 0F.
    parallel_ready = 1'b0;
    send_word(8'hF0);
    check("t4_hold_valid", pvalid_m, 1'b1);
    check("t4_hold_data", pdata_m, 8'hF0);
    pat = 8'h0F;
    for (int i = W - 1; i >= 1; i--) send_bit(pat[i], st);
    check("t4_cnt7", cnt_m, 3'd7);
    check("t4_sready_low", sready_m, 1'b0);
    check("t4_data_still", pdata_m, 8'hF0);
    serial_valid = 1'b1;
    serial_data  = pat[0];
    @(posedge clk);
    #1;
    check("t4_stall_cnt", cnt_m, 3'd7);
    check("t4_stall_data", pdata_m, 8'hF0);
    parallel_ready = 1'b1;
    #1;
    check("t4_sready_up", sready_m, 1'b1);
    @(posedge clk);
    #1;
    parallel_ready = 1'b0;
    serial_valid   = 1'b0;
    check("t4_valid_kept", pvalid_m, 1'b1);
    check("t4_new_m", pdata_m, 8'h0F);
    check("t4_new_l", pdata_l, 8'hF0);
    check("t4_cnt0", cnt_m, 3'd0);
    parallel_ready = 1'b1;
    idle(1);
    check("t4_drained", pvalid_m, 1'b0);

    // T5: continuous 11, 22, 33 with no serial stalls.
    words_m = '{8'h11, 8'h22, 8'h33};
    words_l = '{8'h88, 8'h44, 8'hCC};
    stalls_total = 0;
    for (int k = 0; k < 3; k++) begin
      send_word(words_m[k]);
      check("t5_valid", pvalid_m, 1'b1);
      check("t5_data_m", pdata_m, words_m[k]);
      check("t5_data_l", pdata_l, words_l[k]);
    end
    check("t5_no_stall", stalls_total, 0);
    idle(1);

    // T6: asynchronous reset mid-word, then with a held word, then C3.
    for (int i = 0; i < 5; i++) send_bit(1'b1, st);
    check("t6_cnt5", cnt_m, 3'd5);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_cnt", cnt_m, 3'd0);
    check("t6_rst_valid", pvalid_m, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    parallel_ready = 1'b0;
    send_word(8'h5A);
    check("t6_held", pvalid_m, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_drop", pvalid_m, 1'b0);
    check("t6_rst_data", pdata_m, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    parallel_ready = 1'b1;
    send_word(8'hC3);
    check("t6_valid", pvalid_m, 1'b1);
    check("t6_data_m", pdata_m, 8'hC3);
    check("t6_data_l", pdata_l, 8'hC3);
    check("t6_cnt0", cnt_m, 3'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
